led_pattern_arbiter: RTL and testbench

Shares the board's single user LED between NREQ requesters, each of which wants to flash a 32-slot blink pattern. Arbitrates round-robin, latches the winner's pattern, and plays it LSB-first at a fixed slot rate. Inserts a dark gap between patterns and reports completion per requester. Sits between the status/debug sources and the LED pin in the top level, replacing free-running single-pattern blink logic.

---
 rtl/led_pattern_arbiter.sv | 160 ++++++++++++++++
 tb/tb_led_pattern_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/led_pattern_arbiter.sv
// led_pattern_arbiter: shares one user LED between NREQ requesters.
// Round-robin selects a requester and latches its 32-slot pattern, which is
// then played LSB-first at one slot per TICK_DIV clocks. A dark gap of
// GAP_TICKS slots follows every pattern, whether it completed or was aborted.
//
// state | meaning
// IDLE  | LED dark, waiting for any request; arbitrates and latches on request
// PLAY  | winner granted, LED follows latched pattern bit for current slot
// GAP   | LED dark for GAP_TICKS slots, requests ignored
module led_pattern_arbiter #(
  parameter int NREQ      = 2,
  parameter int TICK_DIV  = 2097152,
  parameter int GAP_TICKS = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [32*NREQ-1:0]   PATTERN,
  output logic [NREQ-1:0]      GRANT,
  output logic [NREQ-1:0]      DONE,
  output logic                 LED,
  output logic                 BUSY
);

  localparam int PW       = $clog2(NREQ);
  localparam int TW       = $clog2(TICK_DIV);
  localparam int GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pat_q, pat_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [4:0]      slot_q, slot_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [NREQ-1:0] done_q, done_d;

  logic            win_found;
  int              win_idx;
  logic            tick_wrap;

  assign tick_wrap = (tick_q == TW'(TICK_DIV - 1));

  // Round-robin search starting one past the last granted index.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = 0;
    cand      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register and datapath registers; synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      rr_ptr_q <= PW'(NREQ - 1);
      tick_q   <= '0;
      slot_q   <= '0;
      gap_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      rr_ptr_q <= rr_ptr_d;
      tick_q   <= tick_d;
      slot_q   <= slot_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: arbitration, slot/tick sequencing, abort and gap timing.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    rr_ptr_d = rr_ptr_q;
    tick_d   = tick_q;
    slot_d   = slot_q;
    gap_d    = gap_q;
    done_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          pat_d    = PATTERN[32*win_idx +: 32];
          rr_ptr_d = PW'(win_idx);
          tick_d   = '0;
          slot_d   = '0;
          state_d  = S_PLAY;
        end
      end

      S_PLAY: begin
        // An abort on the final tick wins over completion: the requester
        // withdrew before the pattern was fully shown.
        if (!REQ[rr_ptr_q]) begin
          tick_d  = '0;
          slot_d  = '0;
          gap_d   = '0;
          state_d = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
        end else if (tick_wrap) begin
          tick_d = '0;
          if (slot_q == 5'd31) begin
            done_d[rr_ptr_q] = 1'b1;
            slot_d  = '0;
            gap_d   = '0;
            state_d = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
          end else begin
            slot_d = slot_q + 5'd1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      S_GAP: begin
        if (tick_wrap) begin
          tick_d = '0;
          if (gap_q == GW'(GAP_LAST)) begin
            gap_d   = '0;
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    GRANT = '0;
    if (state_q == S_PLAY) GRANT[rr_ptr_q] = 1'b1;
    LED   = (state_q == S_PLAY) && pat_q[slot_q];
    BUSY  = (state_q != S_IDLE);
    DONE  = done_q;
  end

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Directed bench for led_pattern_arbiter with NREQ=2, TICK_DIV=4, GAP_TICKS=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_pattern_arbiter;

  localparam int NREQ   = 2;
  localparam int TDIV   = 4;
  localparam int GAPT   = 1;
  localparam int PLAYC  = 32 * TDIV;          // 128 cycles of PLAY
  localparam int GAPC   = GAPT * TDIV;        // 4 cycles of GAP
  localparam int PERIOD = PLAYC + GAPC + 1;   // play + gap + one idle cycle

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [1:0]      REQ = 2'b00;
  logic [31:0]     p0 = '0;
  logic [31:0]     p1 = '0;
  logic [63:0]     PATTERN;
  logic [1:0]      GRANT;
  logic [1:0]      DONE;
  logic            LED;
  logic            BUSY;

  int n_chk = 0;
  int n_err = 0;

  assign PATTERN = {p1, p0};

  led_pattern_arbiter #(
    .NREQ(NREQ), .TICK_DIV(TDIV), .GAP_TICKS(GAPT)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .PATTERN(PATTERN),
    .GRANT(GRANT), .DONE(DONE), .LED(LED), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".grant"}, 32'(GRANT), 32'd0);
    check_eq({tag, ".done"},  32'(DONE),  32'd0);
    check_eq({tag, ".led"},   32'(LED),   32'd0);
    check_eq({tag, ".busy"},  32'(BUSY),  32'd0);
  endtask

  // Holds RST for n edges with random REQ, checking outputs after each edge.
  // Returns at a falling edge with RST released and REQ = req_after.
  task automatic apply_reset(input int n, input logic [1:0] req_after);
    RST = 1'b1;
    REQ = 2'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check_idle_outputs("reset");
      REQ = 2'($urandom_range(0, 3));
    end
    RST = 1'b0;
    REQ = req_after;
  endtask

  // Checks every cycle of back-to-back grants. Cycle c=1 is the first cycle
  // after the grant edge; each grant occupies PERIOD cycles.
  task automatic stream(input string tag, input int ncyc, input int first, input bit alt);
    int p, w;
    logic [31:0] pat, eg, ed, el, eb;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge CLK);
      p   = (c - 1) % PERIOD;
      w   = alt ? (first + (c - 1) / PERIOD) % 2 : first;
      pat = (w == 0) ? p0 : p1;
      eg  = (p < PLAYC)  ? (32'd1 << w) : 32'd0;
      ed  = (p == PLAYC) ? (32'd1 << w) : 32'd0;
      el  = (p < PLAYC)  ? 32'(pat[p / TDIV]) : 32'd0;
      eb  = (p < PLAYC + GAPC) ? 32'd1 : 32'd0;
      check_eq({tag, ".grant"}, 32'(GRANT), eg);
      check_eq({tag, ".done"},  32'(DONE),  ed);
      check_eq({tag, ".led"},   32'(LED),   el);
      check_eq({tag, ".busy"},  32'(BUSY),  eb);
    end
  endtask

  initial begin
    // Reset for 3 cycles with random requests, then one idle cycle.
    apply_reset(3, 2'b00);
    @(negedge CLK);
    check_idle_outputs("post_reset");

    // Single play of 32'h5 by requester 0.
    p0  = 32'h0000_0005;
    REQ = 2'b01;
    stream("single", PERIOD, 0, 1'b0);
    REQ = 2'b00;
    @(negedge CLK);
    check_idle_outputs("single_end");

    // Round-robin with both requesting from reset: 0, 1, 0.
    p0 = 32'hA5A5_0F0F;
    p1 = 32'h1234_5678;
    apply_reset(1, 2'b11);
    stream("rr", 3 * PERIOD, 0, 1'b1);

    // Abort requester 0 during slot 5 while requester 1 waits.
    apply_reset(1, 2'b11);
    stream("abort_pre", 22, 0, 1'b0);
    REQ = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      check_eq("abort.grant", 32'(GRANT), 32'd0);
      check_eq("abort.done",  32'(DONE),  32'd0);
      check_eq("abort.led",   32'(LED),   32'd0);
      check_eq("abort.busy",  32'(BUSY),  (c <= GAPC) ? 32'd1 : 32'd0);
    end
    @(negedge CLK);
    check_eq("abort.grant1", 32'(GRANT), 32'd2);
    check_eq("abort.led1",   32'(LED),   32'(p1[0]));

    // Pattern change after latch must not reach the LED.
    p0 = 32'hFFFF_FFFF;
    apply_reset(1, 2'b01);
    for (int c = 1; c <= PLAYC; c++) begin
      @(negedge CLK);
      check_eq("latch.led",   32'(LED),   32'd1);
      check_eq("latch.grant", 32'(GRANT), 32'd1);
      if (c == 9) p0 = 32'h0000_0000;
    end
    @(negedge CLK);
    check_eq("latch.done", 32'(DONE), 32'd1);
    REQ = 2'b00;
    repeat (GAPC) @(negedge CLK);

    // Reset in slot 10 while requester 0 plays; requester 0 must win again.
    p0 = 32'hFFFF_FFFF;
    apply_reset(1, 2'b11);
    stream("midplay_pre", 41, 0, 1'b0);
    apply_reset(1, 2'b11);
    @(negedge CLK);
    check_eq("midplay.grant", 32'(GRANT), 32'd1);
    check_eq("midplay.done",  32'(DONE),  32'd0);
    check_eq("midplay.led",   32'(LED),   32'd1);
    check_eq("midplay.busy",  32'(BUSY),  32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
